// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - RV32I program-counter stage with stall, debug halt and fetch trap
module pc_fetch_unit #(
    parameter logic [31:0] RESET_VEC  = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 2048
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_stall,
    input  logic        i_pc_sel,
    input  logic [31:0] i_target,
    input  logic        i_halt_req,
    input  logic        i_resume,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_four,
    output logic        o_fetch_valid,
    output logic        o_halted,
    output logic        o_trap,
    output logic [1:0]  o_trap_cause,
    output logic [31:0] o_trap_addr,
    output logic [31:0] o_fetch_cnt
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HALT = 2'd1,
        TRAP = 2'd2
    } state_t;

    localparam logic [1:0]  CAUSE_NONE  = 2'd0;
    localparam logic [1:0]  CAUSE_ALIGN = 2'd1;
    localparam logic [1:0]  CAUSE_RANGE = 2'd2;
    localparam logic [31:0] IMEM_LIMIT  = 32'(IMEM_BYTES);

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] cnt, cnt_nxt;
    logic [31:0] trap_addr, trap_addr_nxt;
    logic [1:0]  cause, cause_nxt;

    // Sequential successor carries bit 32 so a wrap past FFFF_FFFC counts as out of range.
    logic [32:0] seq_sum;
    logic        seq_oor;

    assign seq_sum = {1'b0, pc} + 33'd4;
    assign seq_oor = seq_sum[32] || (seq_sum[31:0] >= IMEM_LIMIT);

    // State and architectural registers; async reset forces everything immediately.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= RUN;
            pc        <= RESET_VEC;
            cnt       <= 32'd0;
            trap_addr <= 32'd0;
            cause     <= CAUSE_NONE;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            cnt       <= cnt_nxt;
            trap_addr <= trap_addr_nxt;
            cause     <= cause_nxt;
        end
    end

    // Next-state: halt beats redirect, redirect beats stall, then sequential advance.
    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        cnt_nxt       = cnt;
        trap_addr_nxt = trap_addr;
        cause_nxt     = cause;
        case (state)
            RUN: begin
                if (i_halt_req) begin
                    state_nxt = HALT;
                end else if (i_pc_sel) begin
                    if (i_target[1:0] != 2'b00) begin
                        state_nxt     = TRAP;
                        cause_nxt     = CAUSE_ALIGN;
                        trap_addr_nxt = i_target;
                    end else if (i_target >= IMEM_LIMIT) begin
                        state_nxt     = TRAP;
                        cause_nxt     = CAUSE_RANGE;
                        trap_addr_nxt = i_target;
                    end else begin
                        pc_nxt  = i_target;
                        cnt_nxt = cnt + 32'd1;
                    end
                end else if (i_stall) begin
                    pc_nxt = pc;
                end else if (seq_oor) begin
                    state_nxt     = TRAP;
                    cause_nxt     = CAUSE_RANGE;
                    trap_addr_nxt = seq_sum[31:0];
                end else begin
                    pc_nxt  = seq_sum[31:0];
                    cnt_nxt = cnt + 32'd1;
                end
            end
            HALT: begin
                if (i_resume) begin
                    state_nxt = RUN;
                end
            end
            TRAP: begin
                if (i_resume) begin
                    state_nxt     = RUN;
                    pc_nxt        = RESET_VEC;
                    cause_nxt     = CAUSE_NONE;
                    trap_addr_nxt = 32'd0;
                end
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    assign o_pc          = pc;
    assign o_pc_four     = seq_sum[31:0];
    assign o_fetch_valid = (state == RUN);
    assign o_halted      = (state == HALT);
    assign o_trap        = (state == TRAP);
    assign o_trap_cause  = cause;
    assign o_trap_addr   = trap_addr;
    assign o_fetch_cnt   = cnt;

endmodule
